// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: commit stage, round-robin single register-file write port plus retire count
// Optional feature macro WB_PERF_EN enables the saturating write-port contention counter.
module vx_commit_arbiter #(
  parameter int NUM_REQS    = 6,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NR_BITS     = 5,
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNT_W = $clog2(NUM_REQS + 1),
  localparam int DW    = NUM_THREADS * 32,
  localparam int IW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_REQS-1:0]             i_req_valid,
  output logic [NUM_REQS-1:0]             o_req_ready,
  input  logic [NUM_REQS*WID_W-1:0]       i_req_wid,
  input  logic [NUM_REQS*32-1:0]          i_req_PC,
  input  logic [NUM_REQS*NUM_THREADS-1:0] i_req_tmask,
  input  logic [NUM_REQS-1:0]             i_req_wb,
  input  logic [NUM_REQS*NR_BITS-1:0]     i_req_rd,
  input  logic [NUM_REQS*DW-1:0]          i_req_data,
  output logic                            o_wb_valid,
  output logic [WID_W-1:0]                o_wb_wid,
  output logic [31:0]                     o_wb_PC,
  output logic [NUM_THREADS-1:0]          o_wb_tmask,
  output logic [NR_BITS-1:0]              o_wb_rd,
  output logic [DW-1:0]                   o_wb_data,
  output logic                            o_cmt_valid,
  output logic [CNT_W-1:0]                o_cmt_count,
  output logic [31:0]                     o_wb_stall_cnt
);
  logic [NUM_REQS-1:0] w_wb_req, w_ret, w_gnt;
  logic [IW-1:0]       w_gnt_idx;
  logic                w_any, w_multi;
  logic [CNT_W-1:0]    w_cnt;
  logic [IW-1:0]       r_ptr;
  logic                r_wb_valid, r_cmt_valid;
  logic [WID_W-1:0]    r_wid;
  logic [31:0]         r_pc;
  logic [NUM_THREADS-1:0] r_tmask;
  logic [NR_BITS-1:0]  r_rd;
  logic [DW-1:0]       r_data;
  logic [CNT_W-1:0]    r_cnt;

  always_comb begin
    w_wb_req = '0;
    w_ret    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_wb_req[i] = i_req_valid[i] & i_req_wb[i] & (|i_req_tmask[i*NUM_THREADS +: NUM_THREADS]);
      w_ret[i]    = i_req_valid[i] & ~(i_req_wb[i] & (|i_req_tmask[i*NUM_THREADS +: NUM_THREADS]));
    end
  end

  // Scan farthest-first so the nearest request after the pointer wins.
  always_comb begin
    w_gnt_idx = r_ptr;
    for (int k = NUM_REQS; k >= 1; k--)
      if (w_wb_req[(int'(r_ptr) + k) % NUM_REQS])
        w_gnt_idx = IW'((int'(r_ptr) + k) % NUM_REQS);
  end

  assign w_any       = |w_wb_req;
  assign w_multi     = |(w_wb_req & (w_wb_req - 1'b1));
  assign w_gnt       = w_any ? (NUM_REQS'(1) << w_gnt_idx) : '0;
  assign o_req_ready = w_ret | w_gnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++)
      w_cnt = w_cnt + CNT_W'(i_req_valid[i] & o_req_ready[i]);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr       <= IW'(NUM_REQS - 1);
      r_wb_valid  <= 1'b0;
      r_wid       <= '0;
      r_pc        <= '0;
      r_tmask     <= '0;
      r_rd        <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_cmt_valid <= 1'b0;
    end else begin
      r_wb_valid  <= w_any;
      r_cnt       <= w_cnt;
      r_cmt_valid <= w_cnt != '0;
      if (w_any) begin
        r_ptr   <= w_gnt_idx;
        r_wid   <= i_req_wid[w_gnt_idx*WID_W +: WID_W];
        r_pc    <= i_req_PC[w_gnt_idx*32 +: 32];
        r_tmask <= i_req_tmask[w_gnt_idx*NUM_THREADS +: NUM_THREADS];
        r_rd    <= i_req_rd[w_gnt_idx*NR_BITS +: NR_BITS];
        r_data  <= i_req_data[w_gnt_idx*DW +: DW];
      end
    end
  end

`ifdef WB_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      r_stall <= '0;
    else if (w_multi && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end
  assign o_wb_stall_cnt = r_stall;
`else
  logic w_unused;
  assign w_unused       = w_multi;
  assign o_wb_stall_cnt = '0;
`endif

  assign o_wb_valid  = r_wb_valid;
  assign o_wb_wid    = r_wid;
  assign o_wb_PC     = r_pc;
  assign o_wb_tmask  = r_tmask;
  assign o_wb_rd     = r_rd;
  assign o_wb_data   = r_data;
  assign o_cmt_valid = r_cmt_valid;
  assign o_cmt_count = r_cnt;
endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb_vx_commit_arbiter: directed checks of grant order, retire-only handling and commit counts
module tb_vx_commit_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   req_valid, req_wb, req_ready;
  logic [11:0]  req_wid;
  logic [191:0] req_PC;
  logic [23:0]  req_tmask;
  logic [29:0]  req_rd;
  logic [767:0] req_data;
  logic         wb_valid, cmt_valid;
  logic [1:0]   wb_wid;
  logic [31:0]  wb_PC, wb_stall_cnt;
  logic [3:0]   wb_tmask;
  logic [4:0]   wb_rd;
  logic [127:0] wb_data;
  logic [2:0]   cmt_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_commit_arbiter dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wid(req_wid), .i_req_PC(req_PC), .i_req_tmask(req_tmask), .i_req_wb(req_wb),
    .i_req_rd(req_rd), .i_req_data(req_data), .o_wb_valid(wb_valid), .o_wb_wid(wb_wid),
    .o_wb_PC(wb_PC), .o_wb_tmask(wb_tmask), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_cmt_valid(cmt_valid), .o_cmt_count(cmt_count), .o_wb_stall_cnt(wb_stall_cnt)
  );

  task automatic clear_reqs();
    req_valid = '0; req_wb = '0; req_wid = '0; req_PC = '0;
    req_tmask = '0; req_rd = '0; req_data = '0;
  endtask

  task automatic set_req(input int i, input logic wb, input logic [1:0] wid,
                         input logic [3:0] tm, input logic [4:0] rd);
    req_valid[i] = 1'b1;
    req_wb[i] = wb;
    req_wid[i*2 +: 2] = wid;
    req_PC[i*32 +: 32] = 32'h1000 + 32'(i * 4);
    req_tmask[i*4 +: 4] = tm;
    req_rd[i*5 +: 5] = rd;
    for (int k = 0; k < 4; k++) req_data[(i*4+k)*32 +: 32] = 32'(i*16 + k + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) set_req(i, 1'b1, 2'd1, 4'hF, 5'(10 + i));
    @(posedge clk); @(posedge clk); #3;
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_traffic wb_valid got %b want 1", wb_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_valid, cmt_valid, cmt_count, wb_rd, wb_wid, wb_PC, wb_tmask} !== '0 || wb_data !== '0 || wb_stall_cnt !== '0) begin
      errors++; $display("FAIL reset_async outputs not zero: wb_valid=%b cmt=%0d rd=%0d stall=%0d", wb_valid, cmt_count, wb_rd, wb_stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 6'b000001) begin
      errors++; $display("FAIL reset_release wb_valid=%b ready=%b want 0 000001", wb_valid, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd10) begin
      errors++; $display("FAIL reset_first_grant wb_valid=%b rd=%0d want 1 10", wb_valid, wb_rd);
    end
    clear_reqs();
  endtask

  task automatic test_single_wb();
    do_reset();
    set_req(0, 1'b1, 2'd2, 4'hF, 5'd5);
    #1;
    checks++;
    if (req_ready !== 6'b000001) begin errors++; $display("FAIL single_ready got %b want 000001", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_wid !== 2'd2 || wb_rd !== 5'd5 || wb_tmask !== 4'hF || wb_PC !== 32'h1000) begin
      errors++; $display("FAIL single_payload valid=%b wid=%0d rd=%0d tm=%h pc=%h", wb_valid, wb_wid, wb_rd, wb_tmask, wb_PC);
    end
    checks++;
    if (wb_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin errors++; $display("FAIL single_data got %h", wb_data); end
    checks++;
    if (cmt_count !== 3'd1 || cmt_valid !== 1'b1) begin errors++; $display("FAIL single_cmt count=%0d valid=%b want 1 1", cmt_count, cmt_valid); end
    @(negedge clk);
    clear_reqs();
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || cmt_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle valid=%b rd=%0d cmt_valid=%b want 0 5 0", wb_valid, wb_rd, cmt_valid);
    end
  endtask

  task automatic test_round_robin();
    int order[10] = '{0, 1, 3, 4, 5, 0, 1, 3, 4, 5};
    do_reset();
    foreach (order[c]) if (c < 5) set_req(order[c], 1'b1, 2'd0, 4'hF, 5'(10 + order[c]));
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (req_ready !== 6'(1 << order[c])) begin errors++; $display("FAIL rr_ready cycle %0d got %b want %b", c, req_ready, 6'(1 << order[c])); end
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'(10 + order[c]) || cmt_count !== 3'd1) begin
        errors++; $display("FAIL rr_wb cycle %0d valid=%b rd=%0d cmt=%0d want rd %0d", c, wb_valid, wb_rd, cmt_count, 10 + order[c]);
      end
      if (c == 9) begin
        checks++;
`ifdef WB_PERF_EN
        if (wb_stall_cnt !== 32'd10) begin errors++; $display("FAIL rr_stall got %0d want 10", wb_stall_cnt); end
`else
        if (wb_stall_cnt !== 32'd0) begin errors++; $display("FAIL rr_stall got %0d want 0", wb_stall_cnt); end
`endif
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_mixed();
    do_reset();
    set_req(2, 1'b0, 2'd0, 4'hF, 5'd9);
    set_req(3, 1'b1, 2'd1, 4'h3, 5'd7);
    #1;
    checks++;
    if (req_ready !== 6'b001100) begin errors++; $display("FAIL mixed_ready got %b want 001100", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (cmt_count !== 3'd2 || wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_tmask !== 4'h3) begin
      errors++; $display("FAIL mixed_out cmt=%0d valid=%b rd=%0d tm=%h want 2 1 7 3", cmt_count, wb_valid, wb_rd, wb_tmask);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_zero_tmask();
    do_reset();
    set_req(4, 1'b1, 2'd3, 4'h0, 5'd12);
    #1;
    checks++;
    if (req_ready !== 6'b010000) begin errors++; $display("FAIL tmask0_ready got %b want 010000", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || cmt_valid !== 1'b1 || cmt_count !== 3'd1) begin
      errors++; $display("FAIL tmask0_out valid=%b cmt_valid=%b cmt=%0d want 0 1 1", wb_valid, cmt_valid, cmt_count);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ready[4] = '{6'b000111, 6'b001000, 6'b010000, 6'b100000};
    logic [2:0] exp_cnt[4]   = '{3'd3, 3'd1, 3'd1, 3'd1};
    int         exp_rd[4]    = '{11, 13, 14, 15};
    do_reset();
    for (int i = 0; i < 6; i++) set_req(i, (i != 0 && i != 2), 2'd0, 4'hF, 5'(10 + i));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready[c]) begin errors++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, req_ready, exp_ready[c]); end
      @(posedge clk); #1;
      checks++;
      if (cmt_count !== exp_cnt[c] || wb_valid !== 1'b1 || wb_rd !== 5'(exp_rd[c])) begin
        errors++; $display("FAIL b2b_out cycle %0d cmt=%0d valid=%b rd=%0d want %0d 1 %0d", c, cmt_count, wb_valid, wb_rd, exp_cnt[c], exp_rd[c]);
      end
      @(negedge clk);
      req_valid = req_valid & ~exp_ready[c];
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || cmt_count !== 3'd0 || cmt_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained valid=%b cmt=%0d want 0 0", wb_valid, cmt_count);
    end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_single_wb();
    test_round_robin();
    test_mixed();
    test_zero_tmask();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
